cluster_link_formatter: RTL and testbench

- Sits directly downstream of the first-8-of-1536 cluster finder in the clock4x domain.
- Once per bunch crossing (bx) it captures the 8 cluster addresses adr0..adr7 and compacts the valid ones to the front.
- It then emits them as four 28-bit link frames, two 14-bit slots per frame, each slot parity-protected.
- Back-to-back bx streaming with no gaps is supported.

---
 rtl/cluster_link_formatter.sv | 158 +++++++++++++++
 tb/tb_cluster_link_formatter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_link_formatter.sv
// Compacts the 8 cluster addresses of each bx and emits them as four 28-bit link frames.
// Optional macro CLUSTER_LINK_BC0_EN: bc0 is carried in the flag bit of frame 0 slot 0.
module cluster_link_formatter #(
  parameter int MAX_ADR       = 1536,
  parameter int FRAMES_PER_BX = 4
) (
  input  logic        clock4x,
  input  logic        global_reset,
  input  logic        bx_strobe,
  input  logic        bc0,
  input  logic [10:0] adr0,
  input  logic [10:0] adr1,
  input  logic [10:0] adr2,
  input  logic [10:0] adr3,
  input  logic [10:0] adr4,
  input  logic [10:0] adr5,
  input  logic [10:0] adr6,
  input  logic [10:0] adr7,
  output logic [27:0] link_data,
  output logic        frame_start,
  output logic [3:0]  cluster_count,
  output logic        sync_err
);

  localparam logic [11:0] MAX_ADR_L  = 12'(MAX_ADR);
  localparam logic [1:0]  LAST_PHASE = 2'(FRAMES_PER_BX - 1);
  localparam logic [27:0] IDLE_LINK  = 28'h3FFFFFF;

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0][10:0] adr_in;
  assign adr_in = {adr7, adr6, adr5, adr4, adr3, adr2, adr1, adr0};

  // Stage 1: raw capture plus validity mask
  logic [7:0][10:0] s1_adr_q;
  logic [7:0]       s1_mask_q;
  logic             s1_vld_q;
  logic             flag0;

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      s1_vld_q  <= 1'b0;
      s1_mask_q <= '0;
      s1_adr_q  <= '1;
    end else begin
      s1_vld_q <= bx_strobe;
      if (bx_strobe) begin
        s1_adr_q <= adr_in;
        for (int i = 0; i < 8; i++) begin
          s1_mask_q[i] <= ({1'b0, adr_in[i]} < MAX_ADR_L);
        end
      end
    end
  end

`ifdef CLUSTER_LINK_BC0_EN
  logic s1_bc0_q;
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      s1_bc0_q <= 1'b0;
    end else if (bx_strobe) begin
      s1_bc0_q <= bc0;
    end
  end
  assign flag0 = s1_bc0_q;
`else
  logic unused_bc0;
  assign unused_bc0 = bc0;
  assign flag0      = 1'b0;
`endif

  // Compaction: valid entries move to the front in input order, the rest stay padded
  logic [7:0][10:0] cmp_adr_d;
  logic [7:0]       cmp_vld_d;
  logic [3:0]       cmp_cnt_d;

  always_comb begin
    cmp_adr_d = '1;
    cmp_vld_d = '0;
    cmp_cnt_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (s1_mask_q[i]) begin
        cmp_adr_d[cmp_cnt_d[2:0]] = s1_adr_q[i];
        cmp_vld_d[cmp_cnt_d[2:0]] = 1'b1;
        cmp_cnt_d                 = cmp_cnt_d + 4'd1;
      end
    end
  end

  function automatic logic [13:0] make_slot(input logic v, input logic f, input logic [10:0] a);
    logic [12:0] body;
    body = {v, f, a};
    return {body, ^body};
  endfunction

  function automatic logic [27:0] make_frame(input logic [1:0] k, input logic [7:0] vld,
                                             input logic [7:0][10:0] adr, input logic f0);
    logic [2:0] i0;
    logic [2:0] i1;
    i0 = {k, 1'b0};
    i1 = {k, 1'b1};
    return {make_slot(vld[i1], 1'b0, adr[i1]),
            make_slot(vld[i0], (k == 2'd0) ? f0 : 1'b0, adr[i0])};
  endfunction

  // Stage 2 and emitter. Frame 0 is formatted straight from the compaction result so it
  // leaves in the same edge that loads the stage-2 list; frames 1..3 read stage 2.
  state_t           state_q;
  logic [1:0]       phase_q;
  logic [7:0][10:0] s2_adr_q;
  logic [7:0]       s2_vld_q;
  logic [27:0]      link_q;
  logic             fs_q;
  logic [3:0]       cnt_q;
  logic             err_q;

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state_q  <= IDLE;
      phase_q  <= 2'd0;
      s2_adr_q <= '1;
      s2_vld_q <= '0;
      link_q   <= IDLE_LINK;
      fs_q     <= 1'b0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
    end else if (s1_vld_q) begin
      if (state_q == SEND && phase_q != LAST_PHASE) begin
        err_q <= 1'b1;
      end
      state_q  <= SEND;
      phase_q  <= 2'd0;
      s2_adr_q <= cmp_adr_d;
      s2_vld_q <= cmp_vld_d;
      cnt_q    <= cmp_cnt_d;
      link_q   <= make_frame(2'd0, cmp_vld_d, cmp_adr_d, flag0);
      fs_q     <= 1'b1;
    end else if (state_q == SEND) begin
      fs_q <= 1'b0;
      if (phase_q == LAST_PHASE) begin
        state_q <= IDLE;
        link_q  <= IDLE_LINK;
      end else begin
        phase_q <= phase_q + 2'd1;
        link_q  <= make_frame(phase_q + 2'd1, s2_vld_q, s2_adr_q, 1'b0);
      end
    end else begin
      fs_q   <= 1'b0;
      link_q <= IDLE_LINK;
    end
  end

  assign link_data     = link_q;
  assign frame_start   = fs_q;
  assign cluster_count = cnt_q;
  assign sync_err      = err_q;

endmodule

// File: tb/tb_cluster_link_formatter.sv
// Directed bench for cluster_link_formatter: a per-cycle expected schedule filled by a
// reference model whenever a strobe or reset is driven, checked on every falling edge.
module tb_cluster_link_formatter;

  localparam int          NCYC      = 256;
  localparam logic [27:0] IDLE_LINK = 28'h3FFFFFF;

  logic        clock4x = 1'b0;
  logic        global_reset;
  logic        bx_strobe;
  logic        bc0;
  logic [10:0] adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7;
  logic [27:0] link_data;
  logic        frame_start;
  logic [3:0]  cluster_count;
  logic        sync_err;

  always #5 clock4x = ~clock4x;

  cluster_link_formatter dut (
    .clock4x      (clock4x),
    .global_reset (global_reset),
    .bx_strobe    (bx_strobe),
    .bc0          (bc0),
    .adr0         (adr0),
    .adr1         (adr1),
    .adr2         (adr2),
    .adr3         (adr3),
    .adr4         (adr4),
    .adr5         (adr5),
    .adr6         (adr6),
    .adr7         (adr7),
    .link_data    (link_data),
    .frame_start  (frame_start),
    .cluster_count(cluster_count),
    .sync_err     (sync_err)
  );

  // Scoreboard: expected outputs per cycle
  logic [27:0] exp_link [NCYC];
  logic        exp_fs   [NCYC];
  logic [3:0]  exp_cnt  [NCYC];
  logic        exp_err  [NCYC];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int last_s = -100;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_slot(input logic v, input logic f, input logic [10:0] a);
    logic [12:0] b;
    b = {v, f, a};
    return {b, ^b};
  endfunction

  function automatic void model_bx(input logic [7:0][10:0] a, input logic b0,
                                   output logic [3:0][27:0] fr, output logic [3:0] n);
    logic [10:0] lst [8];
    logic        vl  [8];
    logic        f0;
    int          k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      lst[i] = 11'h7FF;
      vl[i]  = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (a[i] < 11'd1536) begin
        lst[k] = a[i];
        vl[k]  = 1'b1;
        k++;
      end
    end
    n = 4'(k);
`ifdef CLUSTER_LINK_BC0_EN
    f0 = b0;
`else
    f0 = 1'b0;
`endif
    for (int j = 0; j < 4; j++) begin
      fr[j] = {mk_slot(vl[2*j+1], 1'b0, lst[2*j+1]),
               mk_slot(vl[2*j], (j == 0) ? f0 : 1'b0, lst[2*j])};
    end
  endfunction

  // Driver: check the current cycle, apply inputs for it, update the expected schedule
  task automatic drive(input logic rst, input logic stb, input logic b0,
                       input logic [7:0][10:0] a);
    logic [3:0][27:0] fr;
    logic [3:0]       n;
    int               s;
    if (chk_en) begin
      check_eq("link_data", 32'(link_data), 32'(exp_link[cyc]));
      check_eq("frame_start", 32'(frame_start), 32'(exp_fs[cyc]));
      check_eq("cluster_count", 32'(cluster_count), 32'(exp_cnt[cyc]));
      check_eq("sync_err", 32'(sync_err), 32'(exp_err[cyc]));
    end
    global_reset = rst;
    bx_strobe    = stb;
    bc0          = b0;
    {adr7, adr6, adr5, adr4, adr3, adr2, adr1, adr0} = a;
    if (rst) begin
      for (int j = cyc + 1; j < NCYC; j++) begin
        exp_cnt[j] = 4'd0;
        exp_err[j] = 1'b0;
        if (j <= cyc + 6) begin
          exp_link[j] = IDLE_LINK;
          exp_fs[j]   = 1'b0;
        end
      end
      last_s = -100;
      chk_en = 1'b1;
    end else if (stb) begin
      model_bx(a, b0, fr, n);
      s = cyc + 2;
      for (int k = 0; k < 4; k++) begin
        if (s + k < NCYC) begin
          exp_link[s+k] = fr[k];
          exp_fs[s+k]   = (k == 0);
        end
      end
      for (int j = s; j < NCYC; j++) begin
        exp_cnt[j] = n;
        if (s - last_s < 4) exp_err[j] = 1'b1;
      end
      last_s = s;
    end
    @(negedge clock4x);
    cyc++;
  endtask

  logic [7:0][10:0] none_v;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, none_v);
  endtask

  logic [7:0][10:0] av;

  initial begin
    for (int j = 0; j < NCYC; j++) begin
      exp_link[j] = IDLE_LINK;
      exp_fs[j]   = 1'b0;
      exp_cnt[j]  = 4'd0;
      exp_err[j]  = 1'b0;
    end
    none_v = '1;
    global_reset = 1'b1;
    bx_strobe    = 1'b0;
    bc0          = 1'b0;
    {adr7, adr6, adr5, adr4, adr3, adr2, adr1, adr0} = none_v;
    @(negedge clock4x);

    // Reset for 3 cycles, with a strobe during reset that must be ignored
    drive(1'b1, 1'b0, 1'b0, none_v);
    av = {11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
    drive(1'b1, 1'b1, 1'b1, av);
    drive(1'b1, 1'b0, 1'b0, none_v);
    idle(4);

    // Single valid cluster on adr5 -> frame 0 = 28'h3FFE247
    av = none_v;
    av[5] = 11'h123;
    drive(1'b0, 1'b1, 1'b0, av);
    idle(6);

    // Full list 0..7 with bc0 set
    av = {11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
    drive(1'b0, 1'b1, 1'b1, av);
    idle(6);

    // Back-to-back bx every 4 cycles, including the MAX_ADR boundary
    av = {11'd42, 11'd1537, 11'd1000, 11'd1536, 11'd5, 11'h7FF, 11'd1536, 11'd1535};
    drive(1'b0, 1'b1, 1'b0, av);
    idle(3);
    av = {11'd1536, 11'd1600, 11'h7FF, 11'd2000, 11'd1536, 11'd1536, 11'd1537, 11'h7FE};
    drive(1'b0, 1'b1, 1'b1, av);
    idle(3);
    av = none_v;
    av[7] = 11'd3;
    av[2] = 11'h5AA;
    drive(1'b0, 1'b1, 1'b0, av);
    idle(6);

    // Misaligned strobe two cycles after the previous one
    av = {11'h010, 11'h020, 11'h030, 11'h040, 11'h050, 11'h060, 11'h070, 11'h080};
    drive(1'b0, 1'b1, 1'b0, av);
    idle(1);
    av = {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h2AB, 11'h155};
    drive(1'b0, 1'b1, 1'b0, av);
    idle(7);
    av = {11'd100, 11'd200, 11'd300, 11'd400, 11'd500, 11'd600, 11'd700, 11'd800};
    drive(1'b0, 1'b1, 1'b0, av);
    idle(6);

    // Reset in the middle of emission truncates the bx and clears sync_err
    av = {11'd9, 11'd8, 11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2};
    drive(1'b0, 1'b1, 1'b0, av);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, none_v);
    idle(4);

    // bc0 with no valid cluster
    drive(1'b0, 1'b1, 1'b1, none_v);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
